// File: rtl/bist_response_analyzer_pkg.sv
// rtl/bist_response_analyzer_pkg.sv - shared mode encodings and FSM states for the BIST response path
package bist_response_analyzer_pkg;

  // Generator modes as driven by the BIST control path
  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;
  localparam logic [1:0] MODE_LFSR    = 2'b11;

  // Response analyzer run states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Only a real generator mode may launch a run
  function automatic logic is_run_mode(input logic [1:0] mode);
    return mode != MODE_IDLE;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register with synchronous seed load
module bist_misr #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic             w_feedback;

  assign w_feedback = ^(r_sig & POLY);
  assign sig        = r_sig;

  // Seed load takes priority over compaction so a pattern arriving with start is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= seed;
    end else if (en) begin
      r_sig <= {r_sig[WIDTH-2:0], w_feedback} ^ d;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - compacts the BIST pattern stream and checks it against a per-mode golden signature
module bist_response_analyzer
  import bist_response_analyzer_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               PATTERN_COUNT  = 16,
  parameter logic [WIDTH-1:0] POLY           = 16'hB400,
  parameter logic [WIDTH-1:0] SEED           = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN_RING    = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN_JOHNSON = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN_LFSR    = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             pat_valid,
  input  logic [WIDTH-1:0] pat_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       pat_cnt
);

  if (PATTERN_COUNT < 1 || PATTERN_COUNT > 255) begin : g_bad_pattern_count
    $error("PATTERN_COUNT must lie in 1..255 to fit the 8-bit pattern counter");
  end

  localparam logic [7:0] LAST_CNT = 8'(PATTERN_COUNT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_mode;
  logic [7:0]       r_pat_cnt;
  logic             r_pass;
  logic             r_fail;
  logic             w_start_ok;
  logic             w_compact;
  logic             w_last;
  logic             w_match;
  logic [WIDTH-1:0] w_golden;
  logic [WIDTH-1:0] w_sig;

  assign w_start_ok = start && is_run_mode(mode) && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_compact  = (r_state == ST_COMPACT) && pat_valid;
  assign w_last     = w_compact && (r_pat_cnt == LAST_CNT);
  assign w_match    = (w_sig == w_golden);

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (w_start_ok),
    .seed (SEED),
    .en   (w_compact),
    .d    (pat_in),
    .sig  (w_sig)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state: starts only from rest states, COMPARE lasts exactly one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_next_state = ST_COMPACT;
      ST_COMPACT: if (w_last)     w_next_state = ST_COMPARE;
      ST_COMPARE:                 w_next_state = ST_DONE;
      ST_DONE:    if (w_start_ok) w_next_state = ST_COMPACT;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_COMPACT, ST_COMPARE: busy = 1'b1;
      ST_DONE:                done = 1'b1;
      default: ;
    endcase
  end

  // Pattern counter and mode latch; mode is captured only on an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat_cnt <= '0;
      r_mode    <= MODE_IDLE;
    end else if (w_start_ok) begin
      r_pat_cnt <= '0;
      r_mode    <= mode;
    end else if (w_compact) begin
      r_pat_cnt <= r_pat_cnt + 8'd1;
    end
  end

  // Golden signature for the mode the run was launched with
  always_comb begin
    w_golden = GOLDEN_RING;
    case (r_mode)
      MODE_RING:    w_golden = GOLDEN_RING;
      MODE_JOHNSON: w_golden = GOLDEN_JOHNSON;
      MODE_LFSR:    w_golden = GOLDEN_LFSR;
      default:      w_golden = GOLDEN_RING;
    endcase
  end

  // Verdict is captured in COMPARE and held through DONE until the next run starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_start_ok) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (r_state == ST_COMPARE) begin
      r_pass <= w_match;
      r_fail <= ~w_match;
    end
  end

  assign pass      = r_pass;
  assign fail      = r_fail;
  assign signature = w_sig;
  assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        pat_valid;
  logic [15:0] pat_in;

  logic        a_busy, a_done, a_pass, a_fail;
  logic [15:0] a_sig;
  logic [7:0]  a_cnt;
  logic        b_busy, b_done, b_pass, b_fail;
  logic [15:0] b_sig;
  logic [7:0]  b_cnt;
  logic        c_busy, c_done, c_pass, c_fail;
  logic [15:0] c_sig;
  logic [7:0]  c_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bist_response_analyzer #(.PATTERN_COUNT(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_valid(pat_valid), .pat_in(pat_in),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .signature(a_sig), .pat_cnt(a_cnt)
  );

  bist_response_analyzer #(
    .PATTERN_COUNT(1), .GOLDEN_RING(16'h1234), .GOLDEN_JOHNSON(16'h5678), .GOLDEN_LFSR(16'h00A5)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_valid(pat_valid), .pat_in(pat_in),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .signature(b_sig), .pat_cnt(b_cnt)
  );

  bist_response_analyzer u_dut_c (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_valid(pat_valid), .pat_in(pat_in),
    .busy(c_busy), .done(c_done), .pass(c_pass), .fail(c_fail), .signature(c_sig), .pat_cnt(c_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], ^(s & 16'hB400)} ^ d;
  endfunction

  // Drive one cycle of inputs and return at the following falling edge
  task automatic cyc(input logic st, input logic [1:0] md, input logic pv, input logic [15:0] pd);
    start = st; mode = md; pat_valid = pv; pat_in = pd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, 2'b00, 1'b0, 16'h0);
    rst = 1'b1;
    cyc(1'b0, 2'b00, 1'b0, 16'h0);
  endtask

  logic [15:0] pats [16] = '{16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h1234, 16'h0F0F, 16'hC3C3,
                              16'h0000, 16'h7777, 16'hDEAD, 16'hBEEF, 16'h0100, 16'h4321, 16'h9999, 16'h00FF};
  logic [15:0] exp_sig;

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'b00; pat_valid = 1'b0; pat_in = 16'h0;
    cyc(1'b0, 2'b00, 1'b0, 16'h0);
    cyc(1'b0, 2'b00, 1'b0, 16'h0);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_done", a_done, 1'b0);
    check_eq("rst_pass_fail", {a_pass, a_fail}, 2'b00);
    check_eq("rst_sig", a_sig, 16'h0);
    check_eq("rst_cnt", a_cnt, 8'd0);
    rst = 1'b1;
    cyc(1'b0, 2'b00, 1'b0, 16'h0);

    // mode 00 start is ignored
    cyc(1'b1, 2'b00, 1'b0, 16'h0);
    check_eq("mode00_busy", a_busy, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 16'h0);
    check_eq("mode00_busy2", a_busy, 1'b0);

    // PATTERN_COUNT=2 run; pattern alongside start is dropped
    cyc(1'b1, 2'b01, 1'b1, 16'hFFFF);
    check_eq("a_start_busy", a_busy, 1'b1);
    check_eq("a_start_sig", a_sig, 16'h0000);
    check_eq("a_start_cnt", a_cnt, 8'd0);
    cyc(1'b0, 2'b01, 1'b1, 16'h0001);
    check_eq("a_p1_sig", a_sig, 16'h0001);
    check_eq("a_p1_cnt", a_cnt, 8'd1);
    cyc(1'b0, 2'b01, 1'b1, 16'h0000);
    check_eq("a_compare_busy", a_busy, 1'b1);
    check_eq("a_compare_done", a_done, 1'b0);
    cyc(1'b0, 2'b01, 1'b1, 16'h1234);
    check_eq("a_done", a_done, 1'b1);
    check_eq("a_done_busy", a_busy, 1'b0);
    check_eq("a_sig", a_sig, 16'h0002);
    check_eq("a_cnt", a_cnt, 8'd2);
    check_eq("a_pass_fail", {a_pass, a_fail}, 2'b01);
    cyc(1'b0, 2'b01, 1'b1, 16'h5555);
    check_eq("a_hold_sig", a_sig, 16'h0002);
    check_eq("a_hold_cnt", a_cnt, 8'd2);
    check_eq("a_hold_done", a_done, 1'b1);
    cyc(1'b1, 2'b01, 1'b0, 16'h0);
    check_eq("a_restart_done", a_done, 1'b0);
    check_eq("a_restart_busy", a_busy, 1'b1);
    check_eq("a_restart_sig", a_sig, 16'h0000);
    check_eq("a_restart_cnt", a_cnt, 8'd0);
    check_eq("a_restart_pf", {a_pass, a_fail}, 2'b00);

    // LFSR golden compare, pass then fail
    do_reset();
    cyc(1'b1, 2'b11, 1'b0, 16'h0);
    cyc(1'b0, 2'b11, 1'b1, 16'h00A5);
    cyc(1'b0, 2'b11, 1'b0, 16'h0);
    check_eq("b_pass_done", b_done, 1'b1);
    check_eq("b_pass_sig", b_sig, 16'h00A5);
    check_eq("b_pass_pf", {b_pass, b_fail}, 2'b10);
    cyc(1'b1, 2'b11, 1'b0, 16'h0);
    check_eq("b_rerun_pf", {b_pass, b_fail}, 2'b00);
    check_eq("b_rerun_done", b_done, 1'b0);
    cyc(1'b0, 2'b11, 1'b1, 16'h00A4);
    cyc(1'b0, 2'b11, 1'b0, 16'h0);
    check_eq("b_fail_sig", b_sig, 16'h00A4);
    check_eq("b_fail_pf", {b_pass, b_fail}, 2'b01);

    // Mode switched after start: golden must come from the latched LFSR mode
    cyc(1'b1, 2'b11, 1'b0, 16'h0);
    cyc(1'b0, 2'b01, 1'b1, 16'h00A5);
    cyc(1'b0, 2'b01, 1'b0, 16'h0);
    check_eq("b_latched_pf", {b_pass, b_fail}, 2'b10);

    // 16 patterns with gaps, a start while busy and mode toggling mid-run
    do_reset();
    exp_sig = 16'h0000;
    cyc(1'b1, 2'b10, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, (i % 2 == 1) ? 2'b01 : 2'b11, 1'b1, pats[i]);
      exp_sig = misr_ref(exp_sig, pats[i]);
      if (i == 7) begin
        cyc(1'b1, 2'b11, 1'b0, 16'h0);
        check_eq("c_busy_start_cnt", c_cnt, 8'd8);
        check_eq("c_busy_start_sig", c_sig, exp_sig);
        check_eq("c_busy_start_busy", c_busy, 1'b1);
      end else begin
        cyc(1'b0, 2'b00, 1'b0, 16'h0);
      end
    end
    check_eq("c_done", c_done, 1'b1);
    check_eq("c_sig", c_sig, exp_sig);
    check_eq("c_cnt", c_cnt, 8'd16);
    check_eq("c_pf", {c_pass, c_fail}, (exp_sig == 16'h0000) ? 2'b10 : 2'b01);
    cyc(1'b0, 2'b10, 1'b1, 16'hFFFF);
    check_eq("c_done_hold_sig", c_sig, exp_sig);
    check_eq("c_done_hold_cnt", c_cnt, 8'd16);

    // Asynchronous reset after 5 patterns
    do_reset();
    cyc(1'b1, 2'b01, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b01, 1'b1, pats[i + 2]);
    check_eq("mid_cnt", c_cnt, 8'd5);
    check_eq("mid_busy", c_busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_busy", c_busy, 1'b0);
    check_eq("arst_sig", c_sig, 16'h0);
    check_eq("arst_cnt", c_cnt, 8'd0);
    check_eq("arst_done_pf", {c_done, c_pass, c_fail}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, 1'b1, 16'hBEEF);
    check_eq("post_rst_sig", c_sig, 16'h0);
    check_eq("post_rst_cnt", c_cnt, 8'd0);
    check_eq("post_rst_busy", c_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
